key_debounce_16: RTL and testbench
==================================

KEY_DEBOUNCE_16 -- requirements
Module: key_debounce_16

Interface
REQ-001 The block SHALL expose parameter CLK_DIV, default 50000: system-clock cycles per debounce sample tick (1 ms at 50 MHz), legal range 2..65535.
REQ-002 The block SHALL expose parameter STABLE_N, default 4: consecutive differing sample ticks required to accept a new key level, legal range 1..15.
REQ-003 clk  input  1  system clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 key_n  input  16  raw, unsynchronised, bouncing key lines, active-low (0 = pressed); bit 15 highest priority.
REQ-006 data_hi_n  output  8  debounced key_n[15:8], active-low, for the high-priority 8-to-3 encoder (EI tied low) of the 16-to-4 encoder stage.
REQ-007 data_lo_n  output  8  debounced key_n[7:0], active-low, for the cascaded low-priority encoder.
REQ-008 any_n  output  1  0 when any debounced key is pressed.
REQ-009 press_stb  output  1  one-cycle pulse on a debounced press event.
REQ-010 release_stb  output  1  one-cycle pulse on a debounced release event.

Function
REQ-011 Each key_n bit SHALL pass through a 2-flop synchroniser before any other use; synchroniser flops reset to 1.
REQ-012 A prescaler SHALL count 0..CLK_DIV-1 and wrap to 0; tick SHALL be high for exactly one clk cycle when count = CLK_DIV-1.
REQ-013 Each key i SHALL own a stable bit stable[i] and a 4-bit counter cnt[i]; neither SHALL change on non-tick cycles.
REQ-014 On tick, if sync[i] = stable[i], cnt[i] SHALL clear to 0.
REQ-015 On tick, if sync[i] /= stable[i] and cnt[i]+1 < STABLE_N, cnt[i] SHALL increment by 1.
REQ-016 On tick, if sync[i] /= stable[i] and cnt[i]+1 = STABLE_N, stable[i] SHALL take sync[i] and cnt[i] SHALL clear to 0.
REQ-017 A bounce (sync returns to stable value) before acceptance SHALL clear cnt[i], restarting the count.
REQ-018 data_hi_n SHALL equal stable[15:8] and data_lo_n SHALL equal stable[7:0], registered, no combinational path from key_n.
REQ-019 any_n SHALL be registered AND of all 16 stable bits, updated the cycle after stable changes.
REQ-020 press_stb SHALL pulse for one cycle, in the cycle after the tick, if at least one stable bit changed 1->0 on that tick.
REQ-021 release_stb SHALL pulse likewise for any stable bit changing 0->1; both strobes MAY assert in the same cycle.
REQ-022 Multiple keys changing on the same tick SHALL produce one strobe pulse, not one per key.
REQ-023 Total acceptance latency from a clean key_n edge SHALL be 2 synchroniser cycles plus STABLE_N ticks, plus up to CLK_DIV cycles of tick phase.
REQ-024 Keys SHALL be debounced independently; a change on one key SHALL NOT affect another key's counter.

Reset
REQ-025 While rst = 1, synchronisers, stable bits, data_hi_n, data_lo_n and any_n SHALL be 1; prescaler and all cnt SHALL be 0; press_stb and release_stb SHALL be 0.
REQ-026 rst asserted mid-count SHALL discard partial counts; after release, a held key SHALL need the full STABLE_N ticks again.
REQ-027 First tick after reset release SHALL occur CLK_DIV cycles after the first clk edge with rst = 0.

Verification (CLK_DIV=4, STABLE_N=3)
REQ-028 Reset, key_n=FFFF held -> data_hi_n=FF, data_lo_n=FF, any_n=1, no strobes for 100 cycles.
REQ-029 key_n[15] driven 0 and held -> data_hi_n=7F after exactly 3 ticks, one press_stb pulse next cycle, any_n=0; release -> data_hi_n=FF after 3 ticks, one release_stb.
REQ-030 key_n[3] toggled 0/1 every tick for 10 ticks -> data_lo_n stays FF, no strobes.
REQ-031 key_n[9] and key_n[2] driven 0 on the same cycle -> data_hi_n=FD, data_lo_n=FB on the same tick, single press_stb pulse.
REQ-032 key_n[0] held 0 for 2 ticks, rst pulsed, key still 0 -> data_lo_n=FF until 3 full ticks after reset release, then FE.
REQ-033 Key 5 released while key 12 pressed on the same tick -> press_stb and release_stb both pulse in the same cycle, any_n stays 0.

Source files
------------

// File: rtl/key_debounce_16.sv
// rtl/key_debounce_16.sv - 16-key synchronise/debounce front end for a cascaded 16-to-4 priority encoder
module key_debounce_16 #(
    parameter int CLK_DIV  = 50000,
    parameter int STABLE_N = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] key_n,
    output logic [7:0]  data_hi_n,
    output logic [7:0]  data_lo_n,
    output logic        any_n,
    output logic        press_stb,
    output logic        release_stb
);

    localparam logic [15:0] DIV_LAST   = 16'(CLK_DIV - 1);
    localparam logic [4:0]  STABLE_LIM = 5'(STABLE_N);

    logic [15:0] sync1;
    logic [15:0] sync2;
    logic [15:0] div_cnt;
    logic        tick;
    logic [15:0] stable;
    logic [15:0] stable_nxt;
    logic [3:0]  cnt     [16];
    logic [3:0]  cnt_nxt [16];
    logic        any_fell;
    logic        any_rose;

    // Two-flop synchroniser; idle (released) level is 1.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1 <= '1;
            sync2 <= '1;
        end else begin
            sync1 <= key_n;
            sync2 <= sync1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_cnt <= '0;
        end else if (tick) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + 16'd1;
        end
    end

    assign tick = (div_cnt == DIV_LAST);

    // Per-key counters only move on ticks; a sample matching the stable
    // level (bounce) restarts the count.
    always_comb begin
        stable_nxt = stable;
        for (int i = 0; i < 16; i++) begin
            cnt_nxt[i] = cnt[i];
            if (tick) begin
                if (sync2[i] == stable[i]) begin
                    cnt_nxt[i] = 4'd0;
                end else if (({1'b0, cnt[i]} + 5'd1) == STABLE_LIM) begin
                    stable_nxt[i] = sync2[i];
                    cnt_nxt[i]    = 4'd0;
                end else begin
                    cnt_nxt[i] = cnt[i] + 4'd1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stable <= '1;
            for (int i = 0; i < 16; i++) begin
                cnt[i] <= 4'd0;
            end
        end else begin
            stable <= stable_nxt;
            for (int i = 0; i < 16; i++) begin
                cnt[i] <= cnt_nxt[i];
            end
        end
    end

    assign any_fell = |(stable & ~stable_nxt);
    assign any_rose = |(~stable & stable_nxt);

    // Strobes are OR-reduced so simultaneous key changes give one pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            any_n       <= 1'b1;
            press_stb   <= 1'b0;
            release_stb <= 1'b0;
        end else begin
            any_n       <= &stable;
            press_stb   <= any_fell;
            release_stb <= any_rose;
        end
    end

    assign data_hi_n = stable[15:8];
    assign data_lo_n = stable[7:0];

endmodule

// File: tb/tb_key_debounce_16.sv
// tb/tb_key_debounce_16.sv - directed bench for key_debounce_16 (CLK_DIV=4, STABLE_N=3)
module tb_key_debounce_16;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] key_n;
    logic [7:0]  data_hi_n;
    logic [7:0]  data_lo_n;
    logic        any_n;
    logic        press_stb;
    logic        release_stb;

    int vectors    = 0;
    int miscompares = 0;
    int edge_n     = 0;

    key_debounce_16 #(.CLK_DIV(4), .STABLE_N(3)) dut (
        .clk         (clk),
        .rst         (rst),
        .key_n       (key_n),
        .data_hi_n   (data_hi_n),
        .data_lo_n   (data_lo_n),
        .any_n       (any_n),
        .press_stb   (press_stb),
        .release_stb (release_stb)
    );

    always #5 clk = ~clk;

    // Rising edges since reset release; ticks land on multiples of 4.
    always @(posedge clk) begin
        if (rst) edge_n <= 0;
        else     edge_n <= edge_n + 1;
    end

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic [7:0] hi, input logic [7:0] lo,
                           input logic any, input logic prs, input logic rel);
        chk({tag, ".hi"},  {8'h00, data_hi_n},    {8'h00, hi});
        chk({tag, ".lo"},  {8'h00, data_lo_n},    {8'h00, lo});
        chk({tag, ".any"}, {15'h0, any_n},        {15'h0, any});
        chk({tag, ".prs"}, {15'h0, press_stb},    {15'h0, prs});
        chk({tag, ".rel"}, {15'h0, release_stb},  {15'h0, rel});
    endtask

    task automatic run_to(input int target);
        int guard = 0;
        while (edge_n < target && guard < 20000) begin
            @(negedge clk);
            guard++;
        end
        vectors++;
        if (edge_n != target) begin
            miscompares++;
            $display("FAIL run_to: edge %0d expected %0d", edge_n, target);
        end
    endtask

    initial begin
        rst   = 1'b1;
        key_n = 16'hFFFF;
        repeat (3) @(negedge clk);
        chk_out("reset", 8'hFF, 8'hFF, 1'b1, 1'b0, 1'b0);
        rst = 1'b0;

        for (int i = 1; i <= 100; i++) begin
            run_to(i);
            chk_out("idle", 8'hFF, 8'hFF, 1'b1, 1'b0, 1'b0);
        end

        // key 15 press then release
        key_n[15] = 1'b0;
        run_to(111); chk_out("k15_pre",  8'hFF, 8'hFF, 1'b1, 1'b0, 1'b0);
        run_to(112); chk_out("k15_acc",  8'h7F, 8'hFF, 1'b1, 1'b1, 1'b0);
        run_to(113); chk_out("k15_post", 8'h7F, 8'hFF, 1'b0, 1'b0, 1'b0);
        run_to(116); key_n[15] = 1'b1;
        run_to(127); chk_out("k15_rpre", 8'h7F, 8'hFF, 1'b0, 1'b0, 1'b0);
        run_to(128); chk_out("k15_racc", 8'hFF, 8'hFF, 1'b0, 1'b0, 1'b1);
        run_to(129); chk_out("k15_rpst", 8'hFF, 8'hFF, 1'b1, 1'b0, 1'b0);

        // key 3 bouncing every tick never accepted
        run_to(132);
        for (int j = 0; j < 10; j++) begin
            key_n[3] = j[0];
            for (int c = 1; c <= 4; c++) begin
                run_to(132 + 4 * j + c);
                chk_out("k3_bounce", 8'hFF, 8'hFF, 1'b1, 1'b0, 1'b0);
            end
        end

        // keys 9 and 2 together
        run_to(180);
        key_n[9] = 1'b0;
        key_n[2] = 1'b0;
        run_to(191); chk_out("k9k2_pre",  8'hFF, 8'hFF, 1'b1, 1'b0, 1'b0);
        run_to(192); chk_out("k9k2_acc",  8'hFD, 8'hFB, 1'b1, 1'b1, 1'b0);
        run_to(193); chk_out("k9k2_post", 8'hFD, 8'hFB, 1'b0, 1'b0, 1'b0);
        run_to(196);
        key_n[9] = 1'b1;
        key_n[2] = 1'b1;
        run_to(208); chk_out("k9k2_racc", 8'hFF, 8'hFF, 1'b0, 1'b0, 1'b1);
        run_to(209); chk_out("k9k2_rpst", 8'hFF, 8'hFF, 1'b1, 1'b0, 1'b0);

        // key 0 partial count discarded by reset
        run_to(212);
        key_n[0] = 1'b0;
        run_to(222); chk_out("k0_partial", 8'hFF, 8'hFF, 1'b1, 1'b0, 1'b0);
        rst = 1'b1;
        #1;
        chk_out("k0_inrst", 8'hFF, 8'hFF, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        run_to(8);  chk_out("k0_t2",   8'hFF, 8'hFF, 1'b1, 1'b0, 1'b0);
        run_to(11); chk_out("k0_pre",  8'hFF, 8'hFF, 1'b1, 1'b0, 1'b0);
        run_to(12); chk_out("k0_acc",  8'hFF, 8'hFE, 1'b1, 1'b1, 1'b0);
        run_to(13); chk_out("k0_post", 8'hFF, 8'hFE, 1'b0, 1'b0, 1'b0);

        // key 5 held, then released on the same tick key 12 is pressed
        run_to(16);
        key_n[5] = 1'b0;
        run_to(27); chk_out("k5_pre",  8'hFF, 8'hFE, 1'b0, 1'b0, 1'b0);
        run_to(28); chk_out("k5_acc",  8'hFF, 8'hDE, 1'b0, 1'b1, 1'b0);
        run_to(32);
        key_n[5]  = 1'b1;
        key_n[12] = 1'b0;
        run_to(43); chk_out("swap_pre",  8'hFF, 8'hDE, 1'b0, 1'b0, 1'b0);
        run_to(44); chk_out("swap_acc",  8'hEF, 8'hFE, 1'b0, 1'b1, 1'b1);
        run_to(45); chk_out("swap_post", 8'hEF, 8'hFE, 1'b0, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
